// File: rtl/shifter_if.sv
// Handshake bundle for shifter_pipe: input beat, output result and a synchronous flush.
// Valid/ready rule: a beat moves when valid && ready at a rising edge; while valid && !ready the sender holds its data stable.
interface shifter_if #(
  parameter int WIDTH = 8
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d_in;
  logic [2:0]       op;
  logic [SHW-1:0]   amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_out;
  logic             out_zero;
  logic             out_carry;

  modport master (
    output flush, in_valid, d_in, op, amt, out_ready,
    input  in_ready, out_valid, d_out, out_zero, out_carry
  );

  modport slave (
    input  flush, in_valid, d_in, op, amt, out_ready,
    output in_ready, out_valid, d_out, out_zero, out_carry
  );
endinterface

// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter/rotator with zero and carry-out flags.
// S1 holds the operand, S2 holds the result; log2(WIDTH) mux layers sit between them.
module shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  shifter_if.slave bus
);

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_PASS = 3'b101,
    OP_ZERO = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_d_q, s1_d_d;
  op_e              s1_op_q, s1_op_d;
  logic [SHW-1:0]   s1_amt_q, s1_amt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_d_q, out_d_d;
  logic             out_zero_q, out_zero_d;
  logic             out_carry_q, out_carry_d;

  logic             s2_ready;
  logic             in_ready_w;
  logic             accept;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [SHW-1:0]   sll_idx;
  logic [SHW-1:0]   srl_idx;

  // Layer k conditionally moves the word by 2**k; SRA fill always comes from the operand's MSB.
  logic [WIDTH-1:0] lyr [SHW+1];
  assign lyr[0] = s1_d_q;

  for (genvar k = 0; k < SHW; k++) begin : g_lyr
    localparam int S = 1 << k;
    logic [WIDTH-1:0] moved;
    always_comb begin
      moved = lyr[k];
      case (s1_op_q)
        OP_SLL:  moved = {lyr[k][WIDTH-1-S:0], {S{1'b0}}};
        OP_SRL:  moved = {{S{1'b0}}, lyr[k][WIDTH-1:S]};
        OP_SRA:  moved = {{S{s1_d_q[WIDTH-1]}}, lyr[k][WIDTH-1:S]};
        OP_ROL:  moved = {lyr[k][WIDTH-1-S:0], lyr[k][WIDTH-1:WIDTH-S]};
        OP_ROR:  moved = {lyr[k][S-1:0], lyr[k][WIDTH-1:S]};
        default: moved = lyr[k];
      endcase
    end
    assign lyr[k+1] = s1_amt_q[k] ? moved : lyr[k];
  end

  // WIDTH-amt wraps to -amt in SHW bits; only used when amt != 0.
  always_comb begin
    sll_idx = SHW'(0) - s1_amt_q;
    srl_idx = s1_amt_q - SHW'(1);
    result  = (s1_op_q == OP_ZERO || s1_op_q == OP_RSVD) ? '0 : lyr[SHW];
    carry   = 1'b0;
    if (s1_amt_q != '0) begin
      case (s1_op_q)
        OP_SLL:          carry = s1_d_q[sll_idx];
        OP_SRL, OP_SRA:  carry = s1_d_q[srl_idx];
        OP_ROL:          carry = result[0];
        OP_ROR:          carry = result[WIDTH-1];
        default:         carry = 1'b0;
      endcase
    end
  end

  // Flush wins over a same-cycle accept or consume; in_ready itself ignores flush.
  always_comb begin
    s2_ready    = !out_valid_q || bus.out_ready;
    in_ready_w  = !s1_valid_q || s2_ready;
    accept      = bus.in_valid && in_ready_w && !bus.flush;

    s1_d_d      = s1_d_q;
    s1_op_d     = s1_op_q;
    s1_amt_d    = s1_amt_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;
    out_zero_d  = out_zero_q;
    out_carry_d = out_carry_q;

    if (accept) begin
      s1_d_d   = bus.d_in;
      s1_op_d  = op_e'(bus.op);
      s1_amt_d = bus.amt;
    end
    s1_valid_d = accept || (s1_valid_q && !s2_ready);

    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d_d     = result;
        out_zero_d  = (result == '0);
        out_carry_d = carry;
      end
    end

    if (bus.flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_d_q      <= '0;
      s1_op_q     <= OP_SLL;
      s1_amt_q    <= '0;
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
      out_zero_q  <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_d_q      <= s1_d_d;
      s1_op_q     <= s1_op_d;
      s1_amt_q    <= s1_amt_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
      out_zero_q  <= out_zero_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.d_out     = out_d_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_carry = out_carry_q;

endmodule
